// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter sharing one FIFO write port among
// NUM_REQ requesters in the write clock domain. Once a requester wins, it
// keeps the port until its last beat is accepted, so packets never
// interleave in the FIFO. Per-requester packet counters and a saturating
// full-stall counter are provided for debug.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int CNT_WIDTH  = 16,
  localparam int GW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic [GW-1:0]                 grant_id,
  output logic                          busy,
  output logic [NUM_REQ*CNT_WIDTH-1:0]  pkt_count,
  output logic [CNT_WIDTH-1:0]          stall_count
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e                  state_q;
  logic                    busy_q;
  logic [GW-1:0]           grant_q;
  logic [GW-1:0]           rr_ptr_q;
  logic [CNT_WIDTH-1:0]    pkt_cnt_q [NUM_REQ];
  logic [CNT_WIDTH-1:0]    stall_q;

  logic [DATA_WIDTH-1:0]   data_arr [NUM_REQ];
  logic [2*NUM_REQ-1:0]    rot_valid;
  logic                    win_found;
  int                      win_sum;
  logic [GW-1:0]           win_idx;
  logic                    in_burst;
  logic                    own_valid;
  logic                    last_acc;
  logic [GW-1:0]           next_ptr;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign in_burst  = (state_q == BURST);
  assign own_valid = req_valid[grant_q];
  assign last_acc  = fifo_wr_en && req_last[grant_q];
  assign next_ptr  = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + GW'(1);

  // Round-robin pick: rotate the valid vector so rr_ptr sits at bit 0, take
  // the lowest set bit, then map the offset back to an absolute index.
  always_comb begin
    rot_valid = {req_valid, req_valid} >> rr_ptr_q;
    win_found = 1'b0;
    win_sum   = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot_valid[k]) begin
        win_found = 1'b1;
        win_sum   = int'(rr_ptr_q) + k;
      end
    end
    if (win_sum >= NUM_REQ) begin
      win_sum = win_sum - NUM_REQ;
    end
    win_idx = GW'(win_sum);
  end

  // Only the owner sees ready; it follows fifo_full combinationally.
  always_comb begin
    req_ready = '0;
    if (in_burst) begin
      req_ready[grant_q] = !fifo_full;
    end
  end

  assign fifo_wr_en = in_burst && own_valid && !fifo_full;

  // Unpack the flat requester data bus so the owner's beat can be muxed.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign fifo_wr_data = data_arr[grant_q];

  // Pack the per-requester counters onto the flat debug bus.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      pkt_count[i*CNT_WIDTH +: CNT_WIDTH] = pkt_cnt_q[i];
    end
  end

  assign grant_id    = grant_q;
  assign busy        = busy_q;
  assign stall_count = stall_q;

  // Arbitration FSM: grant in IDLE, hold the lock until the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_found) begin
            state_q <= BURST;
            busy_q  <= 1'b1;
            grant_q <= win_idx;
          end
        end
        BURST: begin
          if (last_acc) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            rr_ptr_q <= next_ptr;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Debug counters: wrapping packet counts, saturating full-stall count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        pkt_cnt_q[i] <= '0;
      end
      stall_q <= '0;
    end else begin
      if (last_acc) begin
        pkt_cnt_q[grant_q] <= pkt_cnt_q[grant_q] + CNT_WIDTH'(1);
      end
      if (in_burst && own_valid && fifo_full) begin
        stall_q <= sat_inc(stall_q);
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (4 requesters, 8-bit beats, 4-bit
// counters so saturation and wrap are reachable quickly). Beat data encodes
// {requester id, beat index} so FIFO contents identify their source.
module tb_fifo_wr_arbiter;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int CW = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_last;
  logic [NR-1:0]     req_ready;
  logic              fifo_full;
  logic              fifo_wr_en;
  logic [DW-1:0]     fifo_wr_data;
  logic [1:0]        grant_id;
  logic              busy;
  logic [NR*CW-1:0]  pkt_count;
  logic [CW-1:0]     stall_count;

  int checks = 0;
  int errors = 0;

  int          src_len  [NR];
  int          src_beat [NR];
  int          src_left [NR];
  logic [NR-1:0] src_hold;

  logic [DW-1:0] wq[$];

  fifo_wr_arbiter #(
    .DATA_WIDTH(DW),
    .NUM_REQ   (NR),
    .CNT_WIDTH (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .fifo_full   (fifo_full),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_wr_data(fifo_wr_data),
    .grant_id    (grant_id),
    .busy        (busy),
    .pkt_count   (pkt_count),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  // Record every beat the FIFO would accept.
  always @(posedge clk) begin
    if (fifo_wr_en) wq.push_back(fifo_wr_data);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = (src_left[i] > 0) && !src_hold[i];
      req_last[i]  = (src_beat[i] == src_len[i] - 1);
      req_data[i*DW +: DW] = {4'(i), 4'(src_beat[i])};
    end
  endtask

  task automatic clear_src();
    for (int i = 0; i < NR; i++) begin
      src_len[i]  = 1;
      src_beat[i] = 0;
      src_left[i] = 0;
    end
    src_hold = '0;
    drive();
  endtask

  // One clock: note accepted beats, advance the requester models, re-drive.
  task automatic tick();
    logic [NR-1:0] acc;
    #1;
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) begin
        if (src_beat[i] == src_len[i] - 1) begin
          src_beat[i] = 0;
          src_left[i] = src_left[i] - 1;
        end else begin
          src_beat[i] = src_beat[i] + 1;
        end
      end
    end
    drive();
    #1;
  endtask

  function automatic logic pending();
    logic p = 1'b0;
    for (int i = 0; i < NR; i++) if (src_left[i] > 0) p = 1'b1;
    return p;
  endfunction

  task automatic run_until_done(input int max_cyc, output int n);
    n = 0;
    while (pending() && n < max_cyc) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    fifo_full = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    clear_src();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",   32'(busy),        32'h0);
    chk("rst_grant",  32'(grant_id),    32'h0);
    chk("rst_wr_en",  32'(fifo_wr_en),  32'h0);
    chk("rst_ready",  32'(req_ready),   32'h0);
    chk("rst_stall",  32'(stall_count), 32'h0);
    chk("rst_pkt",    32'(pkt_count),   32'h0);
    rst_n = 1'b1;

    // Fair rotation: four requesters, two 3-beat packets each.
    for (int i = 0; i < NR; i++) begin
      src_len[i]  = 3;
      src_left[i] = 2;
    end
    drive();
    run_until_done(100, n);
    chk("rot_cycles", 32'(n), 32'd32);
    chk("rot_nbeats", 32'(wq.size()), 32'd24);
    for (int k = 0; k < 24; k++) begin
      chk("rot_data", 32'(wq[k]), 32'({4'((k / 3) % 4), 4'(k % 3)}));
    end
    chk("rot_pkt", 32'(pkt_count), 32'h2222);

    // No interleaving: requester 2 owns the port, goes quiet mid-packet.
    wq.delete();
    src_len[2] = 5; src_left[2] = 1;
    drive();
    tick();
    chk("nil_grant", 32'(grant_id), 32'd2);
    chk("nil_busy",  32'(busy),     32'd1);
    src_len[1] = 1; src_left[1] = 1;
    drive();
    #1;
    chk("nil_ready_a", 32'(req_ready), 32'b0100);
    tick();
    tick();
    src_hold[2] = 1'b1;
    drive();
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("nil_hold_ready", 32'(req_ready),  32'b0100);
      chk("nil_hold_wr",    32'(fifo_wr_en), 32'd0);
      chk("nil_hold_busy",  32'(busy),       32'd1);
      tick();
    end
    src_hold[2] = 1'b0;
    drive();
    tick();
    tick();
    chk("nil_ready_b", 32'(req_ready), 32'b0100);
    tick();
    chk("nil_idle", 32'(busy), 32'd0);
    tick();
    chk("nil_grant1", 32'(grant_id), 32'd1);
    tick();
    chk("nil_nbeats", 32'(wq.size()), 32'd6);
    for (int k = 0; k < 5; k++) chk("nil_data", 32'(wq[k]), 32'({4'd2, 4'(k)}));
    chk("nil_data1", 32'(wq[5]), 32'h10);
    chk("nil_pkt", 32'(pkt_count), 32'h2332);

    // Backpressure: 4 full cycles inside a 4-beat packet from requester 0.
    wq.delete();
    src_len[0] = 4; src_left[0] = 1;
    drive();
    tick();
    chk("bp_grant", 32'(grant_id), 32'd0);
    tick();
    fifo_full = 1'b1;
    #1;
    chk("bp_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("bp_ready", 32'(req_ready),  32'd0);
    repeat (4) tick();
    chk("bp_stall", 32'(stall_count), 32'd4);
    fifo_full = 1'b0;
    run_until_done(20, n);
    chk("bp_cycles", 32'(n), 32'd3);
    chk("bp_nbeats", 32'(wq.size()), 32'd4);
    for (int k = 0; k < 4; k++) chk("bp_data", 32'(wq[k]), 32'({4'd0, 4'(k)}));
    chk("bp_stall_hold", 32'(stall_count), 32'd4);
    chk("bp_pkt", 32'(pkt_count), 32'h2333);

    // Skipping idle requesters: only requester 3, single-beat packets.
    wq.delete();
    src_len[3] = 1; src_left[3] = 3;
    drive();
    run_until_done(20, n);
    chk("skip_cycles", 32'(n), 32'd6);
    chk("skip_nbeats", 32'(wq.size()), 32'd3);
    chk("skip_data",   32'(wq[2]), 32'h30);
    chk("skip_pkt",    32'(pkt_count), 32'h5333);

    // Reset asserted mid-packet while the owner is still valid.
    src_len[0] = 3; src_left[0] = 1;
    drive();
    tick();
    tick();
    chk("mrst_pre_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mrst_wr_en", 32'(fifo_wr_en),  32'd0);
    chk("mrst_ready", 32'(req_ready),   32'd0);
    chk("mrst_busy",  32'(busy),        32'd0);
    chk("mrst_grant", 32'(grant_id),    32'd0);
    chk("mrst_stall", 32'(stall_count), 32'd0);
    chk("mrst_pkt",   32'(pkt_count),   32'd0);
    clear_src();
    for (int i = 0; i < NR; i++) src_left[i] = 1;
    drive();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("mrst_first_grant", 32'(grant_id), 32'd0);
    chk("mrst_first_busy",  32'(busy),     32'd1);
    run_until_done(30, n);
    chk("mrst_cycles", 32'(n), 32'd7);
    chk("mrst_pkt_after", 32'(pkt_count), 32'h1111);

    // Saturation and wrap, starting from a clean reset.
    rst_n = 1'b0;
    clear_src();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    src_len[0] = 2; src_left[0] = 1;
    drive();
    tick();
    fifo_full = 1'b1;
    repeat (20) tick();
    chk("sat_stall", 32'(stall_count), 32'hF);
    fifo_full = 1'b0;
    run_until_done(10, n);
    chk("sat_cycles", 32'(n), 32'd2);
    chk("sat_pkt1", 32'(pkt_count), 32'h0001);
    src_len[0] = 1; src_left[0] = 16;
    drive();
    run_until_done(60, n);
    chk("wrap_cycles", 32'(n), 32'd32);
    chk("wrap_pkt",    32'(pkt_count),   32'h0001);
    chk("wrap_stall",  32'(stall_count), 32'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
